// File: rtl/mem_access_seq.sv
// mem_access_seq: memory-stage sequencer between execute and a byte-wide data/stack memory.
// Accepts word LOAD/STORE/PUSH/POP requests, owns the stack pointer, splits each word into
// four little-endian byte beats and returns load/pop data with its Rd tag over valid/ready.
// Optional feature: define MEM_STACK_GUARD_EN to turn stack overflow/underflow into faults.
module mem_access_seq #(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] SP_INIT     = '0,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 10'h300
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [3:0]        resp_rd,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] sp_out
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         beat_reg;
    logic [2:0]         op_reg;
    logic [ADDR_W-1:0]  base_reg;
    logic [ADDR_W-1:0]  sp_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        resp_data_reg;
    logic [3:0]         resp_rd_reg;
    logic               resp_err_reg;

    // Request decode, evaluated only while IDLE
    logic               accept;
    logic               is_nop, is_ls, is_push, is_pop, is_illegal;
    logic               addr_fault, stack_fault, fault;
    logic [ADDR_W-1:0]  sp_minus4;
    logic [ADDR_W-1:0]  req_base;

    // Latched-op decode used during the beats
    logic               op_is_write, op_is_read;

    // Byte lanes of the latched write word, indexed by beat number
    logic [7:0]         wbyte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign accept      = req_valid && (state_reg == IDLE);
    assign is_nop      = (req_op == OP_NOP);
    assign is_ls       = (req_op == OP_LOAD) || (req_op == OP_STORE);
    assign is_push     = (req_op == OP_PUSH);
    assign is_pop      = (req_op == OP_POP);
    assign is_illegal  = (req_op > OP_POP);
    assign sp_minus4   = sp_reg - ADDR_W'(4);

    // Word alignment plus anything above the memory window is a fault
    assign addr_fault  = is_ls && ((req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W]));

`ifdef MEM_STACK_GUARD_EN
    // Push at the limit would leave the stack region; pop at the reset SP means empty stack
    assign stack_fault = (is_push && (sp_reg == STACK_LIMIT)) || (is_pop && (sp_reg == SP_INIT));
`else
    assign stack_fault = 1'b0;
`endif

    assign fault       = is_illegal || addr_fault || stack_fault;

    // PUSH pre-decrements, POP reads at the current SP
    always_comb begin
        req_base = req_addr[ADDR_W-1:0];
        if (is_push) begin
            req_base = sp_minus4;
        end else if (is_pop) begin
            req_base = sp_reg;
        end
    end

    assign op_is_write = (op_reg == OP_STORE) || (op_reg == OP_PUSH);
    assign op_is_read  = (op_reg == OP_LOAD)  || (op_reg == OP_POP);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: faults skip the beats, NOPs never leave IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid && !is_nop) begin
                    state_next = fault ? RESP : XFER;
                end
            end
            XFER: begin
                if (beat_reg == 2'd3) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshakes and byte strobes decoded from the current state
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: req_ready = 1'b1;
            XFER: begin
                mem_addr = base_reg + ADDR_W'(beat_reg);
                if (op_is_write) begin
                    mem_we    = 1'b1;
                    mem_wdata = wbyte[beat_reg];
                end
                if (op_is_read) begin
                    mem_re = 1'b1;
                end
            end
            RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch the request, gather read bytes, and maintain the stack pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg      <= '0;
            op_reg        <= OP_NOP;
            base_reg      <= '0;
            wdata_reg     <= '0;
            resp_data_reg <= '0;
            resp_rd_reg   <= '0;
            resp_err_reg  <= 1'b0;
            sp_reg        <= SP_INIT;
        end else begin
            if (accept && !is_nop) begin
                op_reg        <= req_op;
                base_reg      <= req_base;
                wdata_reg     <= req_wdata;
                resp_rd_reg   <= req_rd;
                resp_err_reg  <= fault;
                resp_data_reg <= '0;
                beat_reg      <= '0;
                if (is_push && !fault) begin
                    sp_reg <= sp_minus4;
                end
            end else if (state_reg == XFER) begin
                beat_reg <= beat_reg + 2'd1;
                if (op_is_read) begin
                    resp_data_reg[{beat_reg, 3'b000} +: 8] <= mem_rdata;
                end
                // POP releases its slot only once the last byte has been read
                if ((beat_reg == 2'd3) && (op_reg == OP_POP)) begin
                    sp_reg <= sp_reg + ADDR_W'(4);
                end
            end
        end
    end

    assign resp_data = resp_data_reg;
    assign resp_rd   = resp_rd_reg;
    assign resp_err  = resp_err_reg;
    assign sp_out    = sp_reg;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq with a byte-wide behavioural memory attached.
module tb_mem_access_seq;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_rd;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [9:0]  sp_out;

    int total;
    int bad;

    // Observations of the most recent transaction
    int          lat;
    int          n_we;
    int          n_re;
    int          acc_wait;
    logic [31:0] o_data;
    logic        o_err;
    logic [3:0]  o_rd;
    logic [9:0]  obs_addr [8];
    logic [7:0]  obs_wbyte [8];

    // Behavioural memory with a preload port for setting up contents
    logic [7:0]  mem [1024];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [7:0]  pl_data;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    mem_access_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .sp_out     (sp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents one request at the current negedge and records beats and the response
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] rd);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        req_valid = 1'b1;
        acc_wait  = 0;
        while (req_ready !== 1'b1 && acc_wait < 20) begin
            @(negedge clk);
            acc_wait++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = OP_NOP;
        n_we   = 0;
        n_re   = 0;
        lat    = -1;
        o_data = 32'h0;
        o_err  = 1'b0;
        o_rd   = 4'h0;
        for (int c = 1; c <= 12; c++) begin
            if (resp_valid === 1'b1) begin
                lat    = c;
                o_data = resp_data;
                o_err  = resp_err;
                o_rd   = resp_rd;
                break;
            end
            if (mem_we === 1'b1) begin
                if (n_we < 8) begin
                    obs_addr[n_we]  = mem_addr;
                    obs_wbyte[n_we] = mem_wdata;
                end
                n_we++;
            end
            if (mem_re === 1'b1) begin
                if (n_re < 8) obs_addr[n_re] = mem_addr;
                n_re++;
            end
            @(negedge clk);
        end
        if (lat > 0) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rd !== 4'h0 || resp_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_resp: got ready=%b valid=%b err=%b rd=%h data=%h expected 1 0 0 0 00000000",
                     req_ready, resp_valid, resp_err, resp_rd, resp_data);
        end
        total++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 8'h0 || sp_out !== 10'h0) begin
            bad++;
            $display("FAIL reset_mem: got we=%b re=%b addr=%h wdata=%h sp=%h expected 0 0 000 00 000",
                     mem_we, mem_re, mem_addr, mem_wdata, sp_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hD4;
        exp_b[1] = 8'hC3;
        exp_b[2] = 8'hB2;
        exp_b[3] = 8'hA1;
        do_op(OP_STORE, 32'h10, 32'hA1B2C3D4, 4'd1);
        total++;
        if (lat !== 5 || o_err !== 1'b0 || o_data !== 32'h0) begin
            bad++;
            $display("FAIL store_resp: got lat=%0d err=%b data=%h expected lat=5 err=0 data=00000000", lat, o_err, o_data);
        end
        total++;
        if (n_we !== 4 || n_re !== 0) begin
            bad++;
            $display("FAIL store_strobes: got we=%0d re=%0d expected we=4 re=0", n_we, n_re);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_addr[k] !== 10'h10 + 10'(k) || obs_wbyte[k] !== exp_b[k]) begin
                bad++;
                $display("FAIL store_beat%0d: got addr=%h byte=%h expected addr=%h byte=%h",
                         k, obs_addr[k], obs_wbyte[k], 10'h10 + 10'(k), exp_b[k]);
            end
        end
        do_op(OP_LOAD, 32'h10, 32'h0, 4'd5);
        total++;
        if (lat !== 5 || o_err !== 1'b0 || o_data !== 32'hA1B2C3D4 || o_rd !== 4'd5) begin
            bad++;
            $display("FAIL load_resp: got lat=%0d err=%b data=%h rd=%0d expected lat=5 err=0 data=a1b2c3d4 rd=5",
                     lat, o_err, o_data, o_rd);
        end
        total++;
        if (n_re !== 4 || n_we !== 0 || obs_addr[0] !== 10'h10 || obs_addr[3] !== 10'h13) begin
            bad++;
            $display("FAIL load_beats: got re=%0d we=%0d a0=%h a3=%h expected re=4 we=0 a0=010 a3=013",
                     n_re, n_we, obs_addr[0], obs_addr[3]);
        end
    endtask

    task automatic test_stack();
        do_op(OP_PUSH, 32'h0, 32'h11223344, 4'd0);
        total++;
        if (sp_out !== 10'h3FC || lat !== 5 || n_we !== 4 || obs_addr[0] !== 10'h3FC || obs_wbyte[0] !== 8'h44) begin
            bad++;
            $display("FAIL push1: got sp=%h lat=%0d we=%0d a0=%h b0=%h expected sp=3fc lat=5 we=4 a0=3fc b0=44",
                     sp_out, lat, n_we, obs_addr[0], obs_wbyte[0]);
        end
        do_op(OP_PUSH, 32'h0, 32'h55667788, 4'd0);
        total++;
        if (sp_out !== 10'h3F8 || obs_addr[0] !== 10'h3F8 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL push2: got sp=%h a0=%h err=%b expected sp=3f8 a0=3f8 err=0", sp_out, obs_addr[0], o_err);
        end
        do_op(OP_POP, 32'h0, 32'h0, 4'd7);
        total++;
        if (o_data !== 32'h55667788 || sp_out !== 10'h3FC || o_rd !== 4'd7 || obs_addr[0] !== 10'h3F8) begin
            bad++;
            $display("FAIL pop1: got data=%h sp=%h rd=%0d a0=%h expected data=55667788 sp=3fc rd=7 a0=3f8",
                     o_data, sp_out, o_rd, obs_addr[0]);
        end
        do_op(OP_POP, 32'h0, 32'h0, 4'd8);
        total++;
        if (o_data !== 32'h11223344 || sp_out !== 10'h000 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL pop2: got data=%h sp=%h err=%b expected data=11223344 sp=000 err=0", o_data, sp_out, o_err);
        end
    endtask

    task automatic test_faults();
        int seen;
        do_op(OP_LOAD, 32'h12, 32'h0, 4'd2);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || o_data !== 32'h0 || o_rd !== 4'd2 || n_re !== 0 || n_we !== 0) begin
            bad++;
            $display("FAIL misaligned: got lat=%0d err=%b data=%h rd=%0d re=%0d we=%0d expected 1 1 0 2 0 0",
                     lat, o_err, o_data, o_rd, n_re, n_we);
        end
        do_op(OP_STORE, 32'h400, 32'hDEADBEEF, 4'd3);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || n_we !== 0) begin
            bad++;
            $display("FAIL out_of_range: got lat=%0d err=%b we=%0d expected lat=1 err=1 we=0", lat, o_err, n_we);
        end
        do_op(3'd7, 32'h0, 32'h0, 4'd4);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || o_rd !== 4'd4 || sp_out !== 10'h000) begin
            bad++;
            $display("FAIL illegal_op: got lat=%0d err=%b rd=%0d sp=%h expected lat=1 err=1 rd=4 sp=000",
                     lat, o_err, o_rd, sp_out);
        end
        // NOP: accepted, no beats, no response
        req_op    = OP_NOP;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || req_ready !== 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL nop: got %0d cycles with activity expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b0;
        req_op     = OP_LOAD;
        req_addr   = 32'h10;
        req_rd     = 4'd9;
        req_valid  = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_idle: got %b expected 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_data !== 32'hA1B2C3D4 || resp_rd !== 4'd9 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h rd=%0d ready=%b expected 1 a1b2c3d4 9 0",
                         c, resp_valid, resp_data, resp_rd, req_ready);
            end
            if (c < 2) @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", req_ready, resp_valid);
        end
        do_op(OP_LOAD, 32'h3FC, 32'h0, 4'd6);
        total++;
        if (acc_wait !== 0 || lat !== 5 || o_data !== 32'h11223344) begin
            bad++;
            $display("FAIL bp_next: got wait=%0d lat=%0d data=%h expected wait=0 lat=5 data=11223344",
                     acc_wait, lat, o_data);
        end
    endtask

    task automatic test_stack_from_reset();
        apply_reset();
`ifdef MEM_STACK_GUARD_EN
        do_op(OP_POP, 32'h0, 32'h0, 4'd3);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || n_re !== 0 || sp_out !== 10'h000) begin
            bad++;
            $display("FAIL underflow: got lat=%0d err=%b re=%0d sp=%h expected lat=1 err=1 re=0 sp=000",
                     lat, o_err, n_re, sp_out);
        end
        for (int i = 0; i < 64; i++) begin
            do_op(OP_PUSH, 32'h0, 32'(i), 4'd0);
        end
        total++;
        if (sp_out !== 10'h300 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL fill_limit: got sp=%h err=%b expected sp=300 err=0", sp_out, o_err);
        end
        do_op(OP_PUSH, 32'h0, 32'hFFFFFFFF, 4'd1);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || n_we !== 0 || sp_out !== 10'h300) begin
            bad++;
            $display("FAIL overflow: got lat=%0d err=%b we=%0d sp=%h expected lat=1 err=1 we=0 sp=300",
                     lat, o_err, n_we, sp_out);
        end
`else
        preload(10'h000, 8'h01);
        preload(10'h001, 8'h02);
        preload(10'h002, 8'h03);
        preload(10'h003, 8'h04);
        do_op(OP_POP, 32'h0, 32'h0, 4'd3);
        total++;
        if (lat !== 5 || o_err !== 1'b0 || o_data !== 32'h04030201 || sp_out !== 10'h004) begin
            bad++;
            $display("FAIL pop_empty: got lat=%0d err=%b data=%h sp=%h expected lat=5 err=0 data=04030201 sp=004",
                     lat, o_err, o_data, sp_out);
        end
        total++;
        if (n_re !== 4 || obs_addr[0] !== 10'h000 || obs_addr[3] !== 10'h003) begin
            bad++;
            $display("FAIL pop_empty_beats: got re=%0d a0=%h a3=%h expected re=4 a0=000 a3=003",
                     n_re, obs_addr[0], obs_addr[3]);
        end
`endif
    endtask

    task automatic test_reset_mid_beat();
        int seen;
        for (int i = 0; i < 4; i++) preload(10'h020 + 10'(i), 8'h77);
        req_op    = OP_STORE;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEBABE;
        req_rd    = 4'd1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 10'h022 || mem_wdata !== 8'hFE) begin
            bad++;
            $display("FAIL mid_beat2: got we=%b addr=%h wdata=%h expected we=1 addr=022 wdata=fe",
                     mem_we, mem_addr, mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 10'h0 || sp_out !== 10'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_abort: got we=%b addr=%h sp=%h valid=%b ready=%b expected 0 000 000 0 1",
                     mem_we, mem_addr, sp_out, resp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid !== 1'b0 || mem_we !== 1'b0) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_no_resp: got %0d active cycles expected 0", seen);
        end
        total++;
        if (mem[10'h020] !== 8'hBE || mem[10'h021] !== 8'hBA || mem[10'h022] !== 8'h77 || mem[10'h023] !== 8'h77) begin
            bad++;
            $display("FAIL mid_mem: got %h %h %h %h expected be ba 77 77",
                     mem[10'h020], mem[10'h021], mem[10'h022], mem[10'h023]);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = OP_NOP;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 4'h0;
        resp_ready = 1'b1;
        pl_en      = 1'b0;
        pl_addr    = 10'h0;
        pl_data    = 8'h0;
        test_reset();
        test_store_load();
        test_stack();
        test_faults();
        test_back_to_back();
        test_stack_from_reset();
        test_reset_mid_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
